// File: rtl/lfsr_share_arbiter_if.sv
// lfsr_share_arbiter_if: seed, request/grant, random-word handshake and LFSR-side signals
interface lfsr_share_arbiter_if #(
  parameter int NUM_BITS = 128,
  parameter int NUM_REQ  = 4
);
  logic                i_Seed_Load;
  logic [NUM_BITS-1:0] i_Seed_Data;
  logic [NUM_REQ-1:0]  i_Req;
  logic [NUM_REQ-1:0]  o_Gnt;
  logic [NUM_BITS-1:0] o_Rand_Data;
  logic                o_Rand_Valid;
  logic                i_Rand_Ready;
  logic                o_Ready;
  logic                o_Seed_Err;
  logic [15:0]         o_Word_Count;
  logic                o_Lfsr_Enable;
  logic                o_Lfsr_Seed_DV;
  logic [NUM_BITS-1:0] o_Lfsr_Seed;
  logic [NUM_BITS-1:0] i_Lfsr_Data;
  modport slave (
    input  i_Seed_Load, i_Seed_Data, i_Req, i_Rand_Ready, i_Lfsr_Data,
    output o_Gnt, o_Rand_Data, o_Rand_Valid, o_Ready, o_Seed_Err, o_Word_Count,
           o_Lfsr_Enable, o_Lfsr_Seed_DV, o_Lfsr_Seed
  );
  modport master (
    output i_Seed_Load, i_Seed_Data, i_Req, i_Rand_Ready, i_Lfsr_Data,
    input  o_Gnt, o_Rand_Data, o_Rand_Valid, o_Ready, o_Seed_Err, o_Word_Count,
           o_Lfsr_Enable, o_Lfsr_Seed_DV, o_Lfsr_Seed
  );
endinterface

// File: rtl/lfsr_share_arbiter.sv
// lfsr_share_arbiter: seeds and warms a shared XNOR LFSR, round-robin hands out one fresh word per handshake
module lfsr_share_arbiter #(
  parameter int NUM_BITS = 128,
  parameter int NUM_REQ  = 4,
  parameter int WARMUP   = 16
) (
  input logic i_Clk,
  input logic i_Rst_L,
  lfsr_share_arbiter_if.slave bus
);
  localparam int RW = $clog2(NUM_REQ);
  typedef enum logic [2:0] {IDLE, SEED, WARM, ARB, HOLD, STEP} state_t;
  state_t              state_q, state_d;
  logic [RW-1:0]       rr_q, rr_d, sel_q, sel_d, pick;
  logic [7:0]          warm_q, warm_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_BITS-1:0] data_q, data_d, seed_q, seed_d;
  logic                valid_q, valid_d, err_q, err_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                seed_bad, hs;
  int                  j;
  assign seed_bad = &bus.i_Seed_Data;
  assign hs       = valid_q & bus.i_Rand_Ready;
  // first requester at or after the round-robin pointer; scanned backwards so the nearest wins
  always_comb begin
    pick = rr_q;
    j    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (bus.i_Req[j]) pick = RW'(j);
    end
  end
  // next state; a seed load in any state overrides the step in progress
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    sel_d   = sel_q;
    warm_d  = warm_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
    seed_d  = seed_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    if (bus.i_Seed_Load) begin
      valid_d = 1'b0;
      gnt_d   = '0;
      if (seed_bad) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        seed_d  = bus.i_Seed_Data;
        cnt_d   = '0;
        warm_d  = '0;
        state_d = SEED;
      end
    end else begin
      case (state_q)
        SEED: state_d = WARM;
        WARM: begin
          warm_d  = warm_q + 8'd1;
          state_d = (warm_q == 8'(WARMUP - 1)) ? ARB : WARM;
        end
        ARB: if (|bus.i_Req) begin
          sel_d       = pick;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          data_d      = bus.i_Lfsr_Data;
          valid_d     = 1'b1;
          state_d     = HOLD;
        end
        HOLD: if (hs) begin
          valid_d = 1'b0;
          gnt_d   = '0;
          rr_d    = (sel_q == RW'(NUM_REQ - 1)) ? '0 : sel_q + RW'(1);
          cnt_d   = cnt_q + 16'd1;
          state_d = STEP;
        end
        STEP: state_d = ARB;
        default: state_d = IDLE;
      endcase
    end
  end
  // state and datapath registers, synchronous active-low reset
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q <= IDLE;
      rr_q    <= '0;
      sel_q   <= '0;
      warm_q  <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      seed_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      sel_q   <= sel_d;
      warm_q  <= warm_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      seed_q  <= seed_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.o_Gnt          = gnt_q;
  assign bus.o_Rand_Data    = data_q;
  assign bus.o_Rand_Valid   = valid_q;
  assign bus.o_Seed_Err     = err_q;
  assign bus.o_Word_Count   = cnt_q;
  assign bus.o_Lfsr_Seed    = seed_q;
  assign bus.o_Ready        = state_q inside {ARB, HOLD, STEP};
  assign bus.o_Lfsr_Enable  = state_q inside {SEED, WARM, STEP};
  assign bus.o_Lfsr_Seed_DV = state_q == SEED;
endmodule

// File: tb/tb_lfsr_share_arbiter.sv
// tb_lfsr_share_arbiter: directed scoreboard bench with a behavioural XNOR LFSR attached
module tb_lfsr_share_arbiter;
  typedef struct {
    logic [3:0]   g;
    logic [127:0] d;
  } exp_t;
  logic clk = 1'b0;
  logic rst_l;
  int total = 0;
  int bad = 0;
  exp_t exp_q[$];
  exp_t e;
  logic [127:0] seen[$];
  logic [127:0] lfsr = '0;
  int cyc, en_n, dv_n, rdy_c, err_n, val_n;

  lfsr_share_arbiter_if #(.NUM_BITS(128), .NUM_REQ(4)) bus ();

  lfsr_share_arbiter #(.NUM_BITS(128), .NUM_REQ(4), .WARMUP(16)) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_l),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.o_Lfsr_Enable)
      lfsr <= bus.o_Lfsr_Seed_DV ? bus.o_Lfsr_Seed
                                 : {lfsr[126:0], ~(lfsr[127] ^ lfsr[125] ^ lfsr[100] ^ lfsr[98])};
  assign bus.i_Lfsr_Data = lfsr;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // seed 1 only ever shifts ones in for the first ~97 steps: after n steps the word is 2^(n+1)-1
  function automatic logic [127:0] dn(input int n);
    return (128'h1 << (n + 1)) - 128'h1;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input int n);
    exp_q.push_back('{g: g, d: dn(n)});
  endtask

  task automatic seed(input logic [127:0] s);
    @(posedge clk); #1;
    bus.i_Seed_Load = 1'b1;
    bus.i_Seed_Data = s;
    if (!(&s)) seen.delete();
    @(posedge clk); #1;
    bus.i_Seed_Load = 1'b0;
  endtask

  task automatic wait_cnt(input logic [15:0] target, input int lim, output int c_out);
    c_out = 0;
    for (int c = 1; c <= lim; c++) begin
      @(negedge clk);
      if (bus.o_Word_Count == target) begin
        c_out = c;
        break;
      end
    end
    chk("word_count_reach", bus.o_Word_Count, target);
  endtask

  task automatic wait_ready();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.o_Ready) break;
    end
    chk("ready_up", bus.o_Ready, 1);
  endtask

  task automatic get_word(input logic [3:0] req, input logic [3:0] g, input int n);
    logic [15:0] tgt;
    int c;
    tgt = bus.o_Word_Count + 16'd1;
    push(g, n);
    @(posedge clk); #1;
    bus.i_Req = req;
    bus.i_Rand_Ready = 1'b1;
    wait_cnt(tgt, 12, c);
    @(posedge clk); #1;
    bus.i_Req = '0;
  endtask

  initial begin
    fork
      forever begin
        @(negedge clk);
        if (rst_l && bus.o_Rand_Valid && bus.i_Rand_Ready && !bus.i_Seed_Load) begin
          if (exp_q.size() == 0) chk("sb_unexpected_word", exp_q.size(), 1);
          else begin
            int dup;
            e = exp_q.pop_front();
            chk("sb_gnt", bus.o_Gnt, e.g);
            chk("sb_data", bus.o_Rand_Data, e.d);
            dup = 0;
            foreach (seen[i]) if (seen[i] == bus.o_Rand_Data) dup++;
            chk("sb_unique", dup, 0);
            seen.push_back(bus.o_Rand_Data);
          end
        end
      end
    join_none
    rst_l = 1'b0;
    bus.i_Req = 4'hF;
    bus.i_Seed_Load = 1'b1;
    bus.i_Seed_Data = 128'h1;
    bus.i_Rand_Ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", bus.o_Gnt, 0);
    chk("rst_data", bus.o_Rand_Data, 0);
    chk("rst_valid", bus.o_Rand_Valid, 0);
    chk("rst_ready", bus.o_Ready, 0);
    chk("rst_err", bus.o_Seed_Err, 0);
    chk("rst_count", bus.o_Word_Count, 0);
    chk("rst_enable", bus.o_Lfsr_Enable, 0);
    chk("rst_seed_dv", bus.o_Lfsr_Seed_DV, 0);
    chk("rst_seed", bus.o_Lfsr_Seed, 0);
    @(posedge clk); #1;
    rst_l = 1'b1;
    bus.i_Req = '0;
    bus.i_Seed_Load = 1'b0;
    bus.i_Rand_Ready = 1'b0;
    seed(128'h1);
    en_n = 0; dv_n = 0; rdy_c = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      en_n += int'(bus.o_Lfsr_Enable);
      dv_n += int'(bus.o_Lfsr_Seed_DV);
      if (bus.o_Ready && rdy_c == 0) rdy_c = c;
    end
    chk("warm_seed_dv_cycles", dv_n, 1);
    chk("warm_enable_cycles", en_n, 17);
    chk("warm_ready_cycle", rdy_c, 18);
    chk("seed_reg", bus.o_Lfsr_Seed, 128'h1);
    push(4'b0001, 16);
    push(4'b0010, 17);
    push(4'b0100, 18);
    push(4'b1000, 19);
    push(4'b0001, 20);
    @(posedge clk); #1;
    bus.i_Req = 4'hF;
    bus.i_Rand_Ready = 1'b1;
    wait_cnt(16'd5, 40, cyc);
    chk("rr5_cycles", cyc, 15);
    @(posedge clk); #1;
    bus.i_Req = '0;
    push(4'b0100, 21);
    @(posedge clk); #1;
    bus.i_Req = 4'b0100;
    bus.i_Rand_Ready = 1'b0;
    @(posedge clk); #1;
    bus.i_Req = '0;
    val_n = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.o_Rand_Valid && bus.o_Gnt == 4'b0100 && bus.o_Rand_Data == dn(21)) val_n++;
    end
    chk("hold_stable_cycles", val_n, 10);
    push(4'b1000, 22);
    @(posedge clk); #1;
    bus.i_Req = 4'b1001;
    bus.i_Rand_Ready = 1'b1;
    wait_cnt(16'd7, 12, cyc);
    @(posedge clk); #1;
    bus.i_Req = '0;
    get_word(4'b0100, 4'b0100, 23);
    get_word(4'b0011, 4'b0001, 24);
    chk("count9", bus.o_Word_Count, 9);
    @(posedge clk); #1;
    bus.i_Req = 4'b0001;
    bus.i_Rand_Ready = 1'b0;
    @(posedge clk); #1;
    bus.i_Req = 4'hF;
    @(negedge clk);
    chk("pre_reject_valid", bus.o_Rand_Valid, 1);
    @(posedge clk); #1;
    bus.i_Seed_Load = 1'b1;
    bus.i_Seed_Data = '1;
    @(posedge clk); #1;
    bus.i_Seed_Load = 1'b0;
    @(negedge clk);
    chk("reject_err", bus.o_Seed_Err, 1);
    chk("reject_ready", bus.o_Ready, 0);
    chk("reject_valid", bus.o_Rand_Valid, 0);
    chk("reject_gnt", bus.o_Gnt, 0);
    dv_n = int'(bus.o_Lfsr_Seed_DV); err_n = 0; val_n = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      dv_n += int'(bus.o_Lfsr_Seed_DV);
      err_n += int'(bus.o_Seed_Err);
      val_n += int'(bus.o_Rand_Valid);
    end
    chk("reject_err_pulse", err_n, 0);
    chk("reject_no_seed_dv", dv_n, 0);
    chk("reject_idle_no_grant", val_n, 0);
    chk("reject_seed_kept", bus.o_Lfsr_Seed, 128'h1);
    @(posedge clk); #1;
    bus.i_Req = '0;
    seed(128'h1);
    wait_ready();
    chk("reseed_count0", bus.o_Word_Count, 0);
    get_word(4'hF, 4'b0010, 16);
    @(posedge clk); #1;
    bus.i_Req = 4'hF;
    bus.i_Rand_Ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.o_Rand_Valid) break;
    end
    chk("collide_gnt", bus.o_Gnt, 4'b0100);
    chk("collide_pre_count", bus.o_Word_Count, 1);
    @(posedge clk); #1;
    bus.i_Rand_Ready = 1'b1;
    bus.i_Seed_Load = 1'b1;
    bus.i_Seed_Data = 128'h1;
    bus.i_Req = '0;
    seen.delete();
    @(posedge clk); #1;
    bus.i_Seed_Load = 1'b0;
    bus.i_Rand_Ready = 1'b0;
    @(negedge clk);
    chk("collide_valid", bus.o_Rand_Valid, 0);
    chk("collide_count", bus.o_Word_Count, 0);
    chk("collide_seed_dv", bus.o_Lfsr_Seed_DV, 1);
    @(negedge clk);
    chk("collide_warm_dv", bus.o_Lfsr_Seed_DV, 0);
    wait_ready();
    get_word(4'hF, 4'b0100, 16);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
